// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
//   NUM_REQ / SEL_W : number of requesters and width of an owner index
//   CNT_W           : width of the per-grant beat counter
//   state_t         : arbiter FSM states
//   onehot()        : owner index to one-hot grant vector
package rr_mux4_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Bus bundle between the four producers, the arbiter and the single consumer.
//   req       : per-requester valid
//   in_data   : packed requester data, slice i = [i*DW +: DW]
//   ack       : per-requester ready/pop (one-hot or zero)
//   grant     : one-hot channel owner (zero when idle)
//   sel       : index of the current owner
//   out_data  : selected data (zero when not granted)
//   out_valid : output beat valid
//   out_ready : consumer ready
// Modports: slave = arbiter side, master = producer/consumer environment side.
interface rr_mux4_arbiter_if #(
  parameter int DW = 8
);
  import rr_mux4_arbiter_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*DW-1:0] in_data;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    grant;
  logic [SEL_W-1:0]      sel;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  req, in_data, out_ready,
    output ack, grant, sel, out_data, out_valid
  );

  modport master (
    output req, in_data, out_ready,
    input  ack, grant, sel, out_data, out_valid
  );

endinterface

// File: rtl/rr_mux4_arbiter_pick4.sv
// rr_pick4: combinational rotating-priority scan.
//   ptr : index with highest priority this round
//   req : request vector
//   idx : first requester found scanning ptr, ptr+1, ... (mod 4)
//   any : at least one request present (idx is meaningful only then)
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  // Scan from the lowest priority upward so the last hit (offset 0 from
  // ptr) wins. The 2-bit sum wraps 3 -> 0 by itself.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    idx = ptr;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: shares one DW-bit valid/ready channel among 4 requesters.
// A requester is chosen round-robin from ptr, keeps the channel for up to
// MAX_BURST accepted beats (or until it drops req), then priority moves to
// the next index. One idle cycle separates consecutive grants.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rr_mux4_arbiter_if.slave (req/in_data/ack in, grant/sel/out_* out)
// Parameters: DW data width, MAX_BURST beats per grant (1..15).
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux4_arbiter_if.slave     bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 owner_req;
  logic                 beat;

  logic [NUM_REQ-1:0]   ack;
  logic [DW-1:0]        out_data;
  logic                 out_valid;

  rr_pick4 u_pick (
    .ptr (ptr_q),
    .req (bus.req),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_req = bus.req[sel_q];
  assign beat      = (state_q == GRANT) && owner_req && bus.out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          sel_d      = pick_idx;
          grant_d    = onehot(pick_idx);
          beat_cnt_d = '0;
        end
      end

      GRANT: begin
        // A withdrawn owner releases without counting a beat; otherwise the
        // grant ends on the accepted beat that completes the burst.
        if (!owner_req || (beat && (beat_cnt_q == LAST_BEAT))) begin
          state_d = IDLE;
          ptr_d   = sel_q + SEL_W'(1);
          grant_d = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: combinational from the registered owner so that reset clears
  // the channel immediately and a dropped req clears valid in the same cycle.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    ack       = '0;
    if (state_q == GRANT) begin
      out_valid = owner_req;
      out_data  = bus.in_data[int'(sel_q) * DW +: DW];
      ack       = onehot(sel_q) & {NUM_REQ{beat}};
    end
  end

  assign bus.ack       = ack;
  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed scenarios with fixed
// expected timing, then randomized traffic against a transaction-level model
// (owner / next-priority / beats-so-far tracked as plain integers).
module tb_rr_mux4_arbiter;

  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  rr_mux4_arbiter_if #(.DW(DW)) bus ();

  rr_mux4_arbiter #(
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observation vector: {grant, ack, out_valid, sel, out_data}.
  function automatic logic [18:0] obs();
    return {bus.grant, bus.ack, bus.out_valid, bus.sel, bus.out_data};
  endfunction

  function automatic logic [18:0] ev(input logic [3:0] g, input logic [3:0] a,
                                     input logic v, input logic [1:0] s,
                                     input logic [7:0] d);
    return {g, a, v, s, d};
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    next();
    rst = 1'b0;
  endtask

  // Reset state, async clear mid-burst, and ptr=0 after reset.
  task automatic test_reset();
    logic [18:0] o, e;
    rst           = 1'b1;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    #3;
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd0, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_hold: got %b want %b", o, e); end
    next();
    next();
    rst           = 1'b0;
    bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    mid();
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd0, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_idle: got %b want %b", o, e); end
    next();
    for (int b = 0; b < 2; b++) begin
      mid();
      o = obs(); e = ev(4'b0001, 4'b0001, 1'b1, 2'd0, 8'h11); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_beat%0d: got %b want %b", b, o, e); end
      if (b == 0) next();
    end
    // Beat 2 in flight: async reset must clear the channel without an edge.
    #1;
    rst = 1'b1;
    #1;
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd0, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_async: got %b want %b", o, e); end
    next();
    rst = 1'b0;
    mid();
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd0, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_after_idle: got %b want %b", o, e); end
    next();
    mid();
    o = obs(); e = ev(4'b0001, 4'b0001, 1'b1, 2'd0, 8'h11); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_regrant: got %b want %b", o, e); end
  endtask

  // One requester holding req: 4 beats, one idle cycle, granted again.
  task automatic test_single();
    logic [18:0] o, e;
    do_reset();
    bus.req       = 4'b0010;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      mid();
      o = obs(); e = ev(4'b0, 4'b0, 1'b0, (r == 0) ? 2'd0 : 2'd1, 8'h00); checks++;
      if (o !== e) begin failures++; $display("FAIL single_idle r%0d: got %b want %b", r, o, e); end
      next();
      for (int b = 0; b < 4; b++) begin
        bus.in_data[15:8] = 8'(8'h50 + b);
        mid();
        o = obs(); e = ev(4'b0010, 4'b0010, 1'b1, 2'd1, 8'(8'h50 + b)); checks++;
        if (o !== e) begin failures++; $display("FAIL single_beat r%0d b%0d: got %b want %b", r, b, o, e); end
        next();
      end
    end
  endtask

  // All four requesting: 0001, 0010, 0100, 1000, 0001, each 4 beats + bubble.
  task automatic test_contention();
    logic [18:0] o, e;
    int i;
    do_reset();
    bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      mid();
      o = obs(); e = ev(4'b0, 4'b0, 1'b0, (g == 0) ? 2'd0 : 2'((g - 1) % 4), 8'h00); checks++;
      if (o !== e) begin failures++; $display("FAIL cont_idle g%0d: got %b want %b", g, o, e); end
      next();
      i = g % 4;
      for (int b = 0; b < 4; b++) begin
        mid();
        o = obs(); e = ev(oh(i), oh(i), 1'b1, 2'(i), 8'(8'h11 * (i + 1))); checks++;
        if (o !== e) begin failures++; $display("FAIL cont_beat g%0d b%0d: got %b want %b", g, b, o, e); end
        next();
      end
    end
  endtask

  // Requester 2 stalled 3 cycles after beat 1; burst still 4 acked beats.
  task automatic test_backpressure();
    logic [18:0] o, e;
    logic [7:0]  rdy_pat;
    int          acks;
    rdy_pat = 8'b1111_0001;
    acks    = 0;
    do_reset();
    bus.in_data[23:16] = 8'hC7;
    bus.req            = 4'b0100;
    bus.out_ready      = 1'b1;
    mid();
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd0, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL bp_idle: got %b want %b", o, e); end
    next();
    for (int c = 0; c < 8; c++) begin
      bus.out_ready = rdy_pat[c];
      mid();
      if (c < 7) e = ev(4'b0100, rdy_pat[c] ? 4'b0100 : 4'b0000, 1'b1, 2'd2, 8'hC7);
      else       e = ev(4'b0, 4'b0, 1'b0, 2'd2, 8'h00);
      o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL bp_cycle c%0d: got %b want %b", c, o, e); end
      if (bus.ack == 4'b0100) acks++;
      next();
    end
    checks++;
    if (acks !== 4) begin failures++; $display("FAIL bp_total: got %0d beats want 4", acks); end
  endtask

  // Requester 2 withdraws after 2 beats; 3 is served; ptr then points at 0.
  task automatic test_withdraw();
    logic [18:0] o, e;
    do_reset();
    bus.in_data   = {8'h3D, 8'h2B, 8'h00, 8'h0E};
    bus.req       = 4'b1100;
    bus.out_ready = 1'b1;
    mid();
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd0, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL wd_idle: got %b want %b", o, e); end
    next();
    for (int b = 0; b < 2; b++) begin
      mid();
      o = obs(); e = ev(4'b0100, 4'b0100, 1'b1, 2'd2, 8'h2B); checks++;
      if (o !== e) begin failures++; $display("FAIL wd_beat b%0d: got %b want %b", b, o, e); end
      next();
    end
    bus.req = 4'b1000;
    mid();
    o = obs(); e = ev(4'b0100, 4'b0000, 1'b0, 2'd2, 8'h2B); checks++;
    if (o !== e) begin failures++; $display("FAIL wd_drop: got %b want %b", o, e); end
    next();
    mid();
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd2, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL wd_release: got %b want %b", o, e); end
    next();
    for (int b = 0; b < 4; b++) begin
      mid();
      o = obs(); e = ev(4'b1000, 4'b1000, 1'b1, 2'd3, 8'h3D); checks++;
      if (o !== e) begin failures++; $display("FAIL wd_next b%0d: got %b want %b", b, o, e); end
      next();
    end
    // Request arriving in the release cycle: ptr=0 must pick 0 over 3.
    bus.req = 4'b1001;
    mid();
    o = obs(); e = ev(4'b0, 4'b0, 1'b0, 2'd3, 8'h00); checks++;
    if (o !== e) begin failures++; $display("FAIL wd_idle2: got %b want %b", o, e); end
    next();
    mid();
    o = obs(); e = ev(4'b0001, 4'b0001, 1'b1, 2'd0, 8'h0E); checks++;
    if (o !== e) begin failures++; $display("FAIL wd_ptr0: got %b want %b", o, e); end
    next();
  endtask

  // ptr=3 with req=1001: 3 first (0xA5), then wrap to 0 (0x3C).
  task automatic test_wrap();
    logic [18:0] o, e;
    do_reset();
    bus.in_data   = {8'hA5, 8'h77, 8'h00, 8'h3C};
    bus.req       = 4'b0100;
    bus.out_ready = 1'b1;
    next();
    for (int b = 0; b < 4; b++) begin
      mid();
      o = obs(); e = ev(4'b0100, 4'b0100, 1'b1, 2'd2, 8'h77); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_pre b%0d: got %b want %b", b, o, e); end
      next();
    end
    bus.req = 4'b1001;
    for (int g = 0; g < 2; g++) begin
      mid();
      o = obs(); e = ev(4'b0, 4'b0, 1'b0, (g == 0) ? 2'd2 : 2'd3, 8'h00); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_idle g%0d: got %b want %b", g, o, e); end
      next();
      for (int b = 0; b < 4; b++) begin
        mid();
        if (g == 0) e = ev(4'b1000, 4'b1000, 1'b1, 2'd3, 8'hA5);
        else        e = ev(4'b0001, 4'b0001, 1'b1, 2'd0, 8'h3C);
        o = obs(); checks++;
        if (o !== e) begin failures++; $display("FAIL wrap_beat g%0d b%0d: got %b want %b", g, b, o, e); end
        next();
      end
    end
  endtask

  // Random traffic against a transaction-level model.
  task automatic test_random();
    logic [18:0] o, e;
    logic [3:0]  r;
    int m_owner, m_ptr, m_sel, m_beats;
    do_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0;
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) r[i] = ($urandom_range(0, 9) != 0);
        else      r[i] = ($urandom_range(0, 9) < 3);
      end
      bus.req       = r;
      bus.in_data   = 32'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      mid();
      if (m_owner < 0) begin
        e = ev(4'b0, 4'b0, 1'b0, 2'(m_sel), 8'h00);
      end else begin
        e = ev(oh(m_owner),
               (bus.req[m_owner] && bus.out_ready) ? oh(m_owner) : 4'b0,
               bus.req[m_owner], 2'(m_owner), bus.in_data[m_owner*8 +: 8]);
      end
      o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL random c%0d: got %b want %b", c, o, e); end
      // Advance the model with this cycle's inputs.
      if (m_owner < 0) begin
        for (int k = 3; k >= 0; k--) begin
          if (bus.req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        if (m_owner >= 0) begin
          m_sel   = m_owner;
          m_beats = 0;
        end
      end else if (!bus.req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (bus.out_ready) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_withdraw();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one DW-bit output channel among 4 requesters.
- Selects one requester, steers its data through a 4:1 select onto the output, and holds the grant for up to MAX_BURST beats.
- Then rotates priority to the next requester.
- Sits between 4 producer blocks and a single consumer; all transfers use valid/ready handshakes.

Parameters:
- DW, 8, data width per requester and of the output.
- MAX_BURST, 4, maximum beats per grant; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester valid; req[i] high means in_data slice i holds a beat.
- in_data  input  4*DW  packed requester data; slice i is bits [i*DW +: DW].
- ack  output  4  per-requester ready/pop; one-hot or zero.
- grant  output  4  one-hot owner of the channel; zero when idle.
- sel  output  2  index of the current owner; drives the data select.
- out_data  output  DW  selected data; zero when not granted.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ptr=0, sel=0, grant=0, beat_cnt=0.
  - Outputs go to out_valid=0, ack=0, out_data=0 immediately, without waiting for a clock edge.
  - Reset mid-burst aborts the burst; a beat not yet acked is not consumed.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - On the next edge: sel<=i, grant<=onehot(i), beat_cnt<=0, state<=GRANT.
  - If req==0, stay in IDLE.
- GRANT (combinational outputs):
  - out_valid = req[sel].
  - out_data = in_data slice sel.
  - ack[sel] = req[sel] & out_ready; all other ack bits = 0.
- Beat: a transfer occurs when out_valid & out_ready; beat_cnt increments (4-bit counter).
- Leave GRANT, back to IDLE on the next edge, when either:
  - (a) a beat transfers with beat_cnt==MAX_BURST-1, or
  - (b) req[sel]==0 (requester withdrew; no beat counted).
- On leaving GRANT: ptr<=(sel+1) mod 4 with wrap from 3 to 0, grant<=0.
- Latency:
  - req rises at edge N: grant and out_valid are visible after edge N+1; the earliest first beat completes at edge N+2.
  - There is one idle bubble cycle between consecutive grants.
- Backpressure: out_ready=0 freezes beat_cnt and grant. The requester holds its data stable per valid/ready.
- Simultaneous events:
  - req changes on non-owner bits while in GRANT are ignored until the next IDLE.
  - A new req arriving in the same cycle as a release is considered in that IDLE cycle.
- MAX_BURST=1 gives strict per-beat round-robin.
- Invariants:
  - grant is one-hot or zero.
  - grant[sel]=1 whenever state=GRANT.
  - ack is never set without out_valid.

Decomposition:
- Shared package holds:
  - NUM_REQ=4 and SEL_W=2.
  - The state enum {IDLE, GRANT}.
  - The beat counter width constant CNT_W=4.
- One natural sub-module, rr_pick4 (combinational):
  - Inputs: ptr[1:0], req[3:0].
  - Outputs: idx[1:0], any.
  - Rotating priority scan.
- The top holds the FSM, the counter, and the data select.

Test Plan:
1. Reset mid-burst: all req=1111, out_ready=1; assert rst during beat 2 of requester 0 -> grant=0000, out_valid=0 in the same cycle. After release, the first grant is requester 0 (ptr=0).
2. Single requester: req=0010 held, out_ready=1, MAX_BURST=4 -> grant=0010 one cycle after req; 4 beats of in_data slice 1 acked; 1 idle cycle; grant=0010 again.
3. Full contention: req=1111 held, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 beats and is separated by one idle cycle.
4. Backpressure: requester 2 granted, out_ready=0 for 3 cycles after beat 1 -> ack=0, out_data stable, beat_cnt stays 1. The burst still totals exactly 4 acked beats.
5. Early withdrawal: requester 2 drops req after 2 beats while req[3]=1 -> return to IDLE; next grant=1000; ptr becomes 0 after that burst.
6. Wrap-around: ptr=3, req=1001 -> grant 1000 first, then 0001. out_data matches slice 3 then slice 0 (e.g. 0xA5 then 0x3C).
